// File: rtl/bitop_arbiter.sv
// Round-robin front end for one shared adiabatic bitwise datapath: registers the
// winner's operands, steps the four power-clock phase enables, returns the result.
module bitop_arbiter #(
    parameter int WIDTH = 16,
    parameter int LAT   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [WIDTH-1:0] dp_a,
    output logic [WIDTH-1:0] dp_b,
    input  logic [WIDTH-1:0] dp_out,
    output logic             ph_pos,
    output logic             ph_pos2,
    output logic             ph_neg,
    output logic             ph_neg2,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        RESP
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [3:0] cnt;
    logic       last_grant;
    logic       owner;
    logic       grant;
    logic       accept;
    logic       last_cnt;

    // A tie goes to the requester that did not win last time; a lone valid always wins.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else begin
            grant = ~req0_valid;
        end
    end

    assign accept     = (state == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = accept && !grant;
    assign req1_ready = accept && grant;
    assign last_cnt   = (cnt == 4'(LAT - 1));

    always_comb begin
        state_nx  = state;
        ph_pos    = 1'b0;
        ph_pos2   = 1'b0;
        ph_neg    = 1'b0;
        ph_neg2   = 1'b0;
        rsp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = DRIVE;
                end
            end
            DRIVE: begin
                unique case (cnt[1:0])
                    2'd0: ph_pos  = 1'b1;
                    2'd1: ph_pos2 = 1'b1;
                    2'd2: ph_neg  = 1'b1;
                    2'd3: ph_neg2 = 1'b1;
                endcase
                if (last_cnt) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            dp_a       <= '0;
            dp_b       <= '0;
            rsp_data   <= '0;
            rsp_id     <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                dp_a       <= grant ? req1_a : req0_a;
                dp_b       <= grant ? req1_b : req0_b;
                owner      <= grant;
                last_grant <= grant;
                cnt        <= '0;
            end
            if (state == DRIVE) begin
                cnt <= cnt + 4'd1;
                if (last_cnt) begin
                    rsp_data <= dp_out;
                    rsp_id   <= owner;
                end
            end
        end
    end

endmodule

// File: tb/tb_bitop_arbiter.sv
// Directed bench for bitop_arbiter: LAT=4 instance with a response scoreboard,
// plus a LAT=6 instance for the phase wrap and sample-point check.
module tb_bitop_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [15:0] dp_a, dp_b, dp_out, rsp_data;
    logic        ph_pos, ph_pos2, ph_neg, ph_neg2;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [3:0]  ph;

    logic        req0_valid_6, req1_valid_6, req0_ready_6, req1_ready_6;
    logic [15:0] req0_a_6, req0_b_6, req1_a_6, req1_b_6;
    logic [15:0] dp_a_6, dp_b_6, dp_out_6, rsp_data_6;
    logic        ph_pos_6, ph_pos2_6, ph_neg_6, ph_neg2_6;
    logic        rsp_valid_6, rsp_ready_6, rsp_id_6;
    logic [3:0]  ph_6;
    logic [15:0] k6;

    typedef struct packed {
        logic        id;
        logic [15:0] data;
    } sb_t;

    sb_t sbq[$];
    sb_t sb6[$];
    int  checks   = 0;
    int  failures = 0;

    bitop_arbiter #(.WIDTH(16), .LAT(4)) u4 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .dp_a(dp_a), .dp_b(dp_b), .dp_out(dp_out),
        .ph_pos(ph_pos), .ph_pos2(ph_pos2), .ph_neg(ph_neg), .ph_neg2(ph_neg2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
    );

    bitop_arbiter #(.WIDTH(16), .LAT(6)) u6 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid_6), .req0_ready(req0_ready_6), .req0_a(req0_a_6), .req0_b(req0_b_6),
        .req1_valid(req1_valid_6), .req1_ready(req1_ready_6), .req1_a(req1_a_6), .req1_b(req1_b_6),
        .dp_a(dp_a_6), .dp_b(dp_b_6), .dp_out(dp_out_6),
        .ph_pos(ph_pos_6), .ph_pos2(ph_pos2_6), .ph_neg(ph_neg_6), .ph_neg2(ph_neg2_6),
        .rsp_valid(rsp_valid_6), .rsp_ready(rsp_ready_6), .rsp_id(rsp_id_6), .rsp_data(rsp_data_6)
    );

    // OR array model; the LAT=6 model adds the drive-cycle index so a wrong sample point shows.
    assign dp_out   = dp_a | dp_b;
    assign dp_out_6 = (dp_a_6 | dp_b_6) + k6;
    assign ph       = {ph_pos, ph_pos2, ph_neg, ph_neg2};
    assign ph_6     = {ph_pos_6, ph_pos2_6, ph_neg_6, ph_neg2_6};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
        checks++;
        assert (obs_v === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs_v, exp_v);
        end
    endtask

    // Move to the drive point of the next cycle.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Observe the current cycle: scoreboard pops on response handshakes, pushes on accepts.
    task automatic obs();
        sb_t e;
        @(negedge clk);
        chk("ready_excl", {31'b0, req0_ready & req1_ready}, 32'd0);
        if (rsp_valid && rsp_ready) begin
            checks++;
            assert (sbq.size() != 0) else begin
                failures++;
                $error("FAIL sb_unexpected observed=rsp_id %0d data %0h expected=no response", rsp_id, rsp_data);
            end
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("sb_id", rsp_id, e.id);
                chk("sb_data", rsp_data, e.data);
            end
        end
        if (rsp_valid_6 && rsp_ready_6 && sb6.size() != 0) begin
            e = sb6.pop_front();
            chk("sb6_id", rsp_id_6, e.id);
            chk("sb6_data", rsp_data_6, e.data);
        end
        if (req0_valid && req0_ready) begin
            e.id = 1'b0; e.data = req0_a | req0_b; sbq.push_back(e);
        end
        if (req1_valid && req1_ready) begin
            e.id = 1'b1; e.data = req1_a | req1_b; sbq.push_back(e);
        end
        if (req0_valid_6 && req0_ready_6) begin
            e.id = 1'b0; e.data = (req0_a_6 | req0_b_6) + 16'd6; sb6.push_back(e);
        end
    endtask

    task automatic drain();
        bit done;
        done       = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            if (sbq.size() == 0 && !rsp_valid) done = 1'b1;
            else begin
                obs();
                next();
            end
        end
        chk("drain_empty", sbq.size(), 32'd0);
    endtask

    initial begin
        int n_acc;
        int last_c;
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        req0_valid_6 = 1'b0; req1_valid_6 = 1'b0; rsp_ready_6 = 1'b1;
        req0_a_6 = '0; req0_b_6 = '0; req1_a_6 = '0; req1_b_6 = '0;
        k6 = '0;

        next();
        next();
        obs();
        chk("rst_ph", ph, 4'b0000);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_dp_a", dp_a, 16'h0);
        chk("rst_dp_b", dp_b, 16'h0);
        chk("rst_rsp_data", rsp_data, 16'h0);
        chk("rst_rsp_id", rsp_id, 1'b0);
        chk("rst_ready", {req0_ready, req1_ready}, 2'b00);
        next();
        rst = 1'b0;

        // Single op on requester 0
        req0_valid = 1'b1; req0_a = 16'h00F0; req0_b = 16'h0F00; rsp_ready = 1'b1;
        obs();
        chk("single_accept", {req0_ready, req1_ready}, 2'b10);
        next();
        req0_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            obs();
            chk("single_ph", ph, 4'b1000 >> i);
            chk("single_dp_a", dp_a, 16'h00F0);
            chk("single_dp_b", dp_b, 16'h0F00);
            next();
        end
        obs();
        chk("single_rsp_valid", rsp_valid, 1'b1);
        chk("single_rsp_data", rsp_data, 16'h0FF0);
        chk("single_rsp_id", rsp_id, 1'b0);
        chk("single_rsp_ph", ph, 4'b0000);
        next();
        obs();
        chk("single_idle", rsp_valid, 1'b0);
        next();

        // Contention from reset: strict alternation, 6-cycle spacing
        rst = 1'b1;
        req0_valid = 1'b1; req0_a = 16'h1230; req0_b = 16'h0004;
        req1_valid = 1'b1; req1_a = 16'hA0A0; req1_b = 16'h0505;
        next();
        rst = 1'b0;
        n_acc = 0; last_c = 0;
        for (int c = 0; c < 30; c++) begin
            obs();
            if (req0_ready || req1_ready) begin
                chk("cont_id", req1_ready, 32'(n_acc % 2));
                if (n_acc > 0) chk("cont_gap", c - last_c, 32'd6);
                last_c = c;
                n_acc++;
            end
            next();
        end
        chk("cont_count", n_acc, 32'd5);
        drain();

        // Backpressure: 10 stalled cycles in RESP with requester 0 waiting
        req1_valid = 1'b1; req1_a = 16'h8001; req1_b = 16'h0180; rsp_ready = 1'b0;
        obs();
        chk("bp_accept", {req0_ready, req1_ready}, 2'b01);
        next();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 16'h1111; req0_b = 16'h2222;
        for (int i = 0; i < 4; i++) begin
            obs();
            chk("bp_drive_ready", {req0_ready, req1_ready}, 2'b00);
            next();
        end
        for (int s = 0; s < 10; s++) begin
            obs();
            chk("bp_valid", rsp_valid, 1'b1);
            chk("bp_data", rsp_data, 16'h8181);
            chk("bp_id", rsp_id, 1'b1);
            chk("bp_ph", ph, 4'b0000);
            chk("bp_ready", {req0_ready, req1_ready}, 2'b00);
            next();
        end
        rsp_ready = 1'b1;
        obs();
        next();
        obs();
        chk("bp_release_idle", req0_ready, 1'b1);
        next();
        drain();

        // Reset mid-DRIVE: last winner was req0, so this tie goes to req1 and is then dropped
        req0_valid = 1'b1; req0_a = 16'h000F; req0_b = 16'h00F0;
        req1_valid = 1'b1; req1_a = 16'h0F00; req1_b = 16'hF000;
        obs();
        chk("rst_tie_req1", {req0_ready, req1_ready}, 2'b01);
        next();
        req0_valid = 1'b0; req1_valid = 1'b0;
        obs();
        next();
        obs();
        next();
        obs();
        chk("rst_cnt2_ph", ph, 4'b0010);
        rst = 1'b1;
        #1;
        chk("arst_ph", ph, 4'b0000);
        chk("arst_dp_a", dp_a, 16'h0);
        chk("arst_dp_b", dp_b, 16'h0);
        chk("arst_rsp_valid", rsp_valid, 1'b0);
        chk("arst_rsp_data", rsp_data, 16'h0);
        chk("arst_rsp_id", rsp_id, 1'b0);
        if (sbq.size() != 0) void'(sbq.pop_back());
        next();
        next();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            obs();
            chk("arst_no_rsp", rsp_valid, 1'b0);
            next();
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        obs();
        chk("arst_first_tie", {req0_ready, req1_ready}, 2'b10);
        next();
        drain();

        // LAT=6: phase wrap and sample at end of 6th DRIVE cycle
        req0_valid_6 = 1'b1; req0_a_6 = 16'h0300; req0_b_6 = 16'h0030;
        obs();
        chk("lat6_accept", req0_ready_6, 1'b1);
        next();
        req0_valid_6 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            k6 = 16'(i + 1);
            obs();
            chk("lat6_ph", ph_6, 4'b1000 >> (i % 4));
            next();
        end
        obs();
        chk("lat6_rsp_valid", rsp_valid_6, 1'b1);
        chk("lat6_rsp_data", rsp_data_6, 16'h0336);
        next();
        obs();
        chk("lat6_idle", rsp_valid_6, 1'b0);
        chk("lat6_sb_empty", sb6.size(), 32'd0);
        next();

        // Lone requester 1 issuing back-to-back
        req1_valid = 1'b1; req1_a = 16'h4000; req1_b = 16'h0004; rsp_ready = 1'b1;
        n_acc = 0; last_c = 0;
        for (int c = 0; c < 8; c++) begin
            obs();
            chk("lone_no_req0", req0_ready, 1'b0);
            if (req1_ready) begin
                if (n_acc > 0) chk("lone_gap", c - last_c, 32'd6);
                last_c = c;
                n_acc++;
            end
            next();
        end
        chk("lone_count", n_acc, 32'd2);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
